booth_mul_seq_ctrl: RTL and testbench
=====================================

// Module: booth_mul_seq_ctrl
// PURPOSE
//  Upstream sequencer for the 4-bit radix-2 Booth multiplier core.
//  - Takes operand pairs (M, Q) over a valid/ready handshake.
//  - Issues the multiplier's clear and load pulses and times the iteration phase.
//  - Captures the product P and presents it on a valid/ready result port.
//  Sits between the user I/O / LA interface and the multiplier instance in user_proj_example.
// PARAMETERS
//  N           4    operand width; product width is 2*N
//  RUN_CYCLES  N    iteration cycles the multiplier needs after load
// PORTS
//  clk        in   1    single clock; all logic is posedge
//  reset_n    in   1    asynchronous reset, active-low
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    controller can accept an operand pair
//  in_m       in   N    multiplicand, two's complement
//  in_q       in   N    multiplier, two's complement
//  mul_reset  out  1    active-high clear to the multiplier core
//  mul_load   out  1    load strobe to the multiplier core
//  mul_m      out  N    registered multiplicand to the core
//  mul_q      out  N    registered multiplier to the core
//  mul_p      in   2N   product from the core
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer accepts the result
//  out_p      out  2N   captured product, two's complement
//  busy       out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset: clk and reset_n are the only clock/reset; reset is async assert, sync deassert.
//  - While reset_n=0: state=IDLE; in_ready=0; mul_reset=1; mul_load=0; mul_m=mul_q=0;
//    out_valid=0; out_p=0; busy=0.
//  - First edge after release: mul_reset=0; in_ready follows the rule below.
//  FSM (one state per clock unless noted):
//  - IDLE: in_ready = !full.
//    - in_valid & in_ready: latch in_m/in_q into mul_m/mul_q; go to CLR.
//  - CLR: mul_reset=1 (core resets A, Count, P); go to LOAD.
//  - LOAD: mul_load=1; go to RUN; iteration counter = RUN_CYCLES-1.
//  - RUN: hold RUN_CYCLES cycles, counting down to 0; then go to CAPT.
//  - CAPT: at the edge ending CAPT, push mul_p into the result store; go to IDLE.
//  mul_reset and mul_load are registered Moore outputs and are never high together.
//  mul_m/mul_q stay stable from accept until the next accept.
//  Latency: out_valid rises on the 7th rising edge after the accept edge (N=4).
//  Throughput: one operation per 8 cycles max, because IDLE lasts at least 1 cycle.
//  Result port:
//  - Result held stable while out_valid & !out_ready.
//  - Pop on out_valid & out_ready.
//  full: result store cannot take another entry. in_ready is held low while full, so CAPT
//  never overflows the store.
//  Simultaneous capture and pop in the same cycle: both take effect and the entry count is unchanged.
//  Arithmetic: no arithmetic in this block; the product is passed through bit-exact.
//  Reset mid-operation: abandons the operation and flushes all results. mul_reset is held
//  high, so the core is cleared.
//  in_valid high outside IDLE: ignored, because in_ready=0. Operands are not sampled.
// CONFIGURATION
//  BM_RESULT_FIFO_EN defined:
//  - Result store is a 2-entry FIFO; full = (count==2).
//  - out_p = head entry; out_valid = (count!=0).
//  - Lets a new operand start while one earlier result awaits the consumer.
//  BM_RESULT_FIFO_EN undefined:
//  - Result store is a single register; full = out_valid.
//  - A new operand is refused until the result has been taken.
// TESTING
//  1. Reset: reset_n=0 mid-RUN -> outputs immediately at reset values, incl. mul_reset=1;
//     after release: IDLE, in_ready=1.
//  2. Basic: M=3, Q=5, out_ready=1 -> mul_reset pulse, then mul_load pulse, 4 RUN cycles;
//     out_p=8'h0F, out_valid on edge 7 after accept.
//  3. Signed: M=4'hE (-2), Q=3 -> out_p=8'hFA; then M=4'hD (-3), Q=4'hB (-5)
//     -> out_p=8'h0F; no stale state between the two.
//  4. Backpressure, no FIFO: out_ready=0 after the first result -> in_ready stays 0 and
//     out_p is stable; out_ready=1 for one cycle -> pop, in_ready=1 the next cycle.
//  5. Backpressure, BM_RESULT_FIFO_EN: out_ready=0 across 2 ops (3*5, 2*2)
//     -> count=2, in_ready=0; drain gives 8'h0F then 8'h04 in order.
//  6. Simultaneous capture and pop: time out_ready so the pop lands in CAPT
//     -> no result lost or duplicated.

Source files
------------

// File: rtl/booth_mul_seq_ctrl.sv
// rtl/booth_mul_seq_ctrl.sv - operand/result sequencer for the radix-2 Booth multiplier core (optional BM_RESULT_FIFO_EN: 2-entry result FIFO)
module booth_mul_seq_ctrl #(
  parameter int N          = 4,
  parameter int RUN_CYCLES = N
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_q,
  output logic             mul_reset,
  output logic             mul_load,
  output logic [N-1:0]     mul_m,
  output logic [N-1:0]     mul_q,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             busy
);

  localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_CAPT
  } state_t;

  state_t          state;
  logic [CW-1:0]   run_cnt;
  logic            accept;
  logic            push;
  logic            pop;
  logic            full_nxt;

  assign accept = (state == S_IDLE) && in_valid && in_ready;
  assign push   = (state == S_CAPT);
  assign pop    = out_valid && out_ready;

`ifdef BM_RESULT_FIFO_EN
  logic [2*N-1:0] fifo_mem [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     count;
  logic [1:0]     count_nxt;

  // Occupancy after this edge; capture and pop together leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  assign full_nxt  = (count_nxt == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_p     = fifo_mem[rd_ptr];

  // Two-entry result FIFO; acceptance is gated on space, so a capture never finds it full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mul_p;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_nxt;
    end
  end
`else
  logic [2*N-1:0] res_q;
  logic           res_valid;

  assign full_nxt  = push || (res_valid && !pop);
  assign out_valid = res_valid;
  assign out_p     = res_q;

  // Single result register; a capture overrides a same-cycle pop so the new result survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q     <= '0;
      res_valid <= 1'b0;
    end else if (push) begin
      res_q     <= mul_p;
      res_valid <= 1'b1;
    end else if (pop) begin
      res_valid <= 1'b0;
    end
  end
`endif

  // Sequencer FSM; every core strobe and handshake output is a registered Moore output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mul_reset <= 1'b1;
      mul_load  <= 1'b0;
      mul_m     <= '0;
      mul_q     <= '0;
      run_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      mul_reset <= 1'b0;
      mul_load  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_m     <= in_m;
            mul_q     <= in_q;
            mul_reset <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CLR;
          end else begin
            in_ready <= !full_nxt;
          end
        end
        S_CLR: begin
          mul_load <= 1'b1;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          run_cnt <= CW'(RUN_CYCLES - 1);
          state   <= S_RUN;
        end
        S_RUN: begin
          if (run_cnt == '0) begin
            state <= S_CAPT;
          end else begin
            run_cnt <= run_cnt - 1'b1;
          end
        end
        S_CAPT: begin
          busy     <= 1'b0;
          in_ready <= !full_nxt;
          state    <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// tb/tb_booth_mul_seq_ctrl.sv - randomized scoreboard bench for booth_mul_seq_ctrl
module tb_booth_mul_seq_ctrl;

`ifdef BM_RESULT_FIFO_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_m;
  logic [3:0] in_q;
  logic       mul_reset;
  logic       mul_load;
  logic [3:0] mul_m;
  logic [3:0] mul_q;
  logic [7:0] mul_p;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_mul_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
    .mul_reset (mul_reset),
    .mul_load  (mul_load),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier core: clears on mul_reset, loads on mul_load, product ready 4 cycles later.
  logic [3:0] core_m;
  logic [3:0] core_q;
  logic [2:0] core_cnt;
  logic [7:0] core_p;
  logic [7:0] core_em;
  logic [7:0] core_eq;
  assign core_em = {{4{core_m[3]}}, core_m};
  assign core_eq = {{4{core_q[3]}}, core_q};
  assign mul_p   = core_p;

  always @(posedge clk) begin
    if (mul_reset) begin
      core_p   <= 8'h00;
      core_cnt <= 3'd0;
    end else if (mul_load) begin
      core_m   <= mul_m;
      core_q   <= mul_q;
      core_cnt <= 3'd4;
    end else if (core_cnt != 3'd0) begin
      core_cnt <= core_cnt - 3'd1;
      if (core_cnt == 3'd1) core_p <= core_em * core_eq;
    end
  end

  // Reference model state
  int         cyc = 0;
  int         last_acc = -100;
  logic [3:0] cur_m = 4'h0;
  logic [3:0] cur_q = 4'h0;
  logic [7:0] exp_p [$];
  int         exp_t [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
    int a;
    int b;
    a = m[3] ? int'(m) - 16 : int'(m);
    b = q[3] ? int'(q) - 16 : int'(q);
    return 8'((a * b) & 255);
  endfunction

  function automatic int stored_results();
    int n = 0;
    foreach (exp_t[i]) if (exp_t[i] <= cyc) n++;
    return n;
  endfunction

  // Called at a falling edge: check outputs against the model, drive inputs, advance one cycle.
  task automatic step(input logic iv, input logic [3:0] m, input logic [3:0] q, input logic ordy);
    int   d;
    int   st;
    logic e_busy;
    logic e_valid;
    logic e_rdy;
    d       = cyc - last_acc;
    st      = stored_results();
    e_busy  = (d >= 0) && (d < LAT);
    e_valid = (st > 0);
    e_rdy   = !e_busy && (st < CAP);
    chk("busy", busy, e_busy);
    chk("mul_reset", mul_reset, d == 0);
    chk("mul_load", mul_load, d == 1);
    chk("out_valid", out_valid, e_valid);
    if (e_valid) chk("out_p", out_p, exp_p[0]);
    chk("in_ready", in_ready, e_rdy);
    chk("mul_m", mul_m, cur_m);
    chk("mul_q", mul_q, cur_q);
    in_valid  = iv;
    in_m      = m;
    in_q      = q;
    out_ready = ordy;
    @(posedge clk);
    cyc++;
    if (ordy && e_valid) begin
      void'(exp_p.pop_front());
      void'(exp_t.pop_front());
    end
    if (iv && e_rdy) begin
      last_acc = cyc;
      cur_m    = m;
      cur_q    = q;
      exp_p.push_back(ref_prod(m, q));
      exp_t.push_back(cyc + LAT);
    end
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check the reset values immediately, release and clear the model.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mul_reset", mul_reset, 1'b1);
    chk("rst_mul_load", mul_load, 1'b0);
    chk("rst_mul_m", mul_m, 4'h0);
    chk("rst_mul_q", mul_q, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    last_acc = -100;
    cur_m    = 4'h0;
    cur_q    = 4'h0;
    exp_p.delete();
    exp_t.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_m      = 4'h0;
    in_q      = 4'h0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    step(1'b0, 4'h0, 4'h0, 1'b1);

    // Basic 3*5
    step(1'b1, 4'h3, 4'h5, 1'b1);
    repeat (9) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Signed: -2*3, then -3*-5
    step(1'b1, 4'hE, 4'h3, 1'b1);
    repeat (8) step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b1, 4'hD, 4'hB, 1'b1);
    repeat (9) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Backpressure: 3*5 then 2*2 offered while the consumer stalls, then drain one at a time
    step(1'b1, 4'h3, 4'h5, 1'b0);
    repeat (10) step(1'b1, 4'h2, 4'h2, 1'b0);
    repeat (12) step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b1);
    repeat (10) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Reset in the middle of RUN
    step(1'b1, 4'h7, 4'h6, 1'b1);
    repeat (4) step(1'b0, 4'h0, 4'h0, 1'b1);
    do_reset();
    repeat (2) step(1'b0, 4'h0, 4'h0, 1'b1);

    // Random traffic, including pops landing in the capture cycle
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 9) < 6));
    end
    repeat (12) step(1'b0, 4'h0, 4'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
